pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the program memory.
- Owns the program counter, drives the memory address combinationally and captures the returned word into an instruction register (IR).
- Hands the IR to the decoder over a valid/ready handshake.
- Handles jump, call and return redirects, the latter two through a small hardware return stack, plus halt.

Parameters:
- ADDR_W, 5, program address width (32 words).
- INSTR_W, 6, instruction word width.
- RESET_ADDR, 0, PC value after reset.
- STACK_DEPTH, 4, return-stack entries (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pm_adr  out  ADDR_W  program-memory address; equals PC, combinational.
- pm_data  in  INSTR_W  program-memory read data, valid the same cycle as pm_adr.
- ir  out  INSTR_W  registered instruction.
- ir_pc  out  ADDR_W  address the current ir was fetched from.
- ir_valid  out  1  ir holds an instruction for the decoder.
- ir_ready  in  1  decoder consumes ir this cycle.
- jmp_en  in  1  absolute jump to jmp_adr.
- call_en  in  1  push ir_pc+1, jump to jmp_adr.
- ret_en  in  1  pop return address into PC.
- jmp_adr  in  ADDR_W  jump/call target.
- halt  in  1  stop fetching.
- halted  out  1  halt state reached.
- stack_ovf  out  1  sticky: call with stack full.
- stack_unf  out  1  sticky: return with stack empty.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - PC=RESET_ADDR, ir=0, ir_pc=0, ir_valid=0.
  - halted=0, stack_ovf=0, stack_unf=0, stack emptied.
  - Reset overrides every other input, including mid-redirect and while halted.
- consume = ir_valid & ir_ready.
- advance = !halted & (!ir_valid | ir_ready).
- Redirect inputs (jmp_en, call_en, ret_en, halt) are sampled only when consume=1; otherwise they are ignored.
- State machine RUN/HALT:
  - RUN→HALT when consume & halt.
  - HALT is left only by reset.
- Sequential fetch, when advance and no redirect:
  - ir<=pm_data, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
  - PC wraps modulo 2^ADDR_W (31→0).
- Stall: if ir_valid & !ir_ready, PC, ir and ir_pc hold.
- Redirect priority: ret > call > jmp.
  - Only the highest applies.
  - On any redirect, ir_valid<=0 (the sequential word is discarded) and PC<=target.
  - Next cycle pm_adr=target; the following edge captures pm[target]. Penalty is one bubble cycle.
- call:
  - If not full: push ir_pc+1 (wrapped), PC<=jmp_adr.
  - If full: no push, stack_ovf<=1, jump still taken.
- ret:
  - If not empty: PC<=top, pop.
  - If empty: stack_unf<=1, PC<=RESET_ADDR.
- halt together with a redirect: the redirect updates PC, then halted<=1 and ir_valid<=0. pm_adr continues to show the frozen PC.
- Latency: first valid instruction appears one cycle after reset release (ir=pm[RESET_ADDR], ir_valid=1).
- stack_ovf and stack_unf clear only on reset.

Decomposition:
- Shared package pm_pkg: ADDR_W, INSTR_W, RESET_ADDR constants; addr_t and instr_t typedefs.
- One sub-module ret_stack:
  - Parameters STACK_DEPTH, ADDR_W.
  - Interface: push, pop, din, top, full, empty.
  - Push and pop are never asserted together by pc_fetch.

Test Plan:
Bench models the program memory as pm[a] = {1'b0, a}.
- Reset then run with ir_ready=1 → ir_valid=0 at cycle 0; ir=0,1,2… from cycle 1; at pm_adr=31 the next pm_adr=0 (wrap).
- ir_ready=0 for 3 cycles while ir=5 → ir, ir_pc and pm_adr stay at 5 / 5 / 6; resumes with ir=6.
- jmp_en with jmp_adr=20 while ir_pc=3 is consumed → one cycle with ir_valid=0, then ir=20, then 21.
- call to 10 at ir_pc=4, then ret when ir_pc=12 → bubble, ir=10…12, bubble, ir=5; stack ends empty.
- Five nested calls with STACK_DEPTH=4 → stack_ovf=1 after the fifth, jump taken. A ret on the empty stack → stack_unf=1, next ir_pc=0.
- halt consumed at ir_pc=7, then rst_n=0 for one cycle → halted=1, ir_valid stays 0 and pm_adr=8 frozen; after reset all outputs return to reset values and fetch restarts at 0.

Source files
------------

// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - shared program-memory constants, types and fetch states
package pm_pkg;

    localparam int ADDR_W      = 5;
    localparam int INSTR_W     = 6;
    localparam int RESET_ADDR  = 0;
    localparam int STACK_DEPTH = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Fetch state encoding; HALT is sticky until reset.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - shift-register return-address stack for call/return
module ret_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    // Entry 0 is always the top, so reading never needs a pointer.
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [CW-1:0]     cnt_q;

    assign top   = mem_q[0];
    assign full  = (cnt_q == CW'(STACK_DEPTH));
    assign empty = (cnt_q == '0);

    // Push shifts entries down, pop shifts them up; requests on a full/empty stack are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[0] <= din;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
            cnt_q <= cnt_q + CW'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                mem_q[i] <= mem_q[i+1];
            end
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage with PC, IR, redirects and halt
module pc_fetch #(
    parameter int ADDR_W      = pm_pkg::ADDR_W,
    parameter int INSTR_W     = pm_pkg::INSTR_W,
    parameter int RESET_ADDR  = pm_pkg::RESET_ADDR,
    parameter int STACK_DEPTH = pm_pkg::STACK_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pm_adr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jmp_en,
    input  logic               call_en,
    input  logic               ret_en,
    input  logic [ADDR_W-1:0]  jmp_adr,
    input  logic               halt,
    output logic               halted,
    output logic               stack_ovf,
    output logic               stack_unf
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               valid_q, valid_d;
    logic [0:0]         state_q, state_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               consume;
    logic               advance;
    logic               stk_push;
    logic               stk_pop;
    logic [ADDR_W-1:0]  stk_top;
    logic               stk_full;
    logic               stk_empty;
    logic [ADDR_W-1:0]  ret_addr;

    assign consume  = valid_q && ir_ready;
    assign advance  = (state_q == pm_pkg::ST_RUN) && (!valid_q || ir_ready);
    assign ret_addr = ir_pc_q + ADDR_W'(1);

    assign pm_adr    = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = valid_q;
    assign halted    = (state_q == pm_pkg::ST_HALT);
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

    ret_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (ret_addr),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-state: redirects (ret > call > jmp) and halt only act on a consumed word.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        valid_d  = valid_q;
        state_d  = state_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (advance) begin
            if (consume && ret_en) begin
                valid_d = 1'b0;
                if (stk_empty) begin
                    unf_d = 1'b1;
                    pc_d  = ADDR_W'(RESET_ADDR);
                end else begin
                    stk_pop = 1'b1;
                    pc_d    = stk_top;
                end
            end else if (consume && call_en) begin
                valid_d = 1'b0;
                pc_d    = jmp_adr;
                if (stk_full) begin
                    ovf_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
            end else if (consume && jmp_en) begin
                valid_d = 1'b0;
                pc_d    = jmp_adr;
            end else if (!(consume && halt)) begin
                ir_d    = pm_data;
                ir_pc_d = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
            end
            if (consume && halt) begin
                state_d = pm_pkg::ST_HALT;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_ADDR);
            ir_q    <= '0;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
            state_q <= pm_pkg::ST_RUN;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch
module tb_pc_fetch;

    localparam int AW    = 5;
    localparam int IW    = 6;
    localparam int DEPTH = 4;
    localparam int NADR  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pm_adr;
    logic [IW-1:0] pm_data;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          jmp_en;
    logic          call_en;
    logic          ret_en;
    logic [AW-1:0] jmp_adr;
    logic          halt;
    logic          halted;
    logic          stack_ovf;
    logic          stack_unf;

    int checks = 0;
    int errors = 0;

    assign pm_data = {1'b0, pm_adr};

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pm_adr    (pm_adr),
        .pm_data   (pm_data),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jmp_en    (jmp_en),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .jmp_adr   (jmp_adr),
        .halt      (halt),
        .halted    (halted),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    typedef struct {
        logic rst_n, ready, jmp, call, ret, hlt;
        int   adr;
        logic exp_valid;
        int   exp_at;
        int   exp_pm;
        logic exp_halted;
    } vec_t;

    vec_t tbl[$];

    // behavioural reference state
    int   m_pc, m_ir, m_irpc;
    bit   m_valid, m_halted, m_ovf, m_unf;
    int   m_stk[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jmp_en  = 1'b0;
        call_en = 1'b0;
        ret_en  = 1'b0;
        halt    = 1'b0;
        jmp_adr = '0;
        ir_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic v(input logic r, input logic rdy, input logic j, input logic c,
                     input logic rt, input logic h, input int adr,
                     input logic ev, input int eat, input int epm, input logic eh);
        vec_t e;
        e.rst_n = r; e.ready = rdy; e.jmp = j; e.call = c; e.ret = rt; e.hlt = h;
        e.adr = adr; e.exp_valid = ev; e.exp_at = eat; e.exp_pm = epm; e.exp_halted = eh;
        tbl.push_back(e);
    endtask

    // Reference model: one clock edge of the fetch stage computed from the stated rules.
    task automatic model_step(input logic r, input logic rdy, input logic j, input logic c,
                              input logic rt, input logic h, input int adr);
        if (!r) begin
            m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0;
            m_halted = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (!m_halted) begin
            if (m_valid && !rdy) begin
                // stalled
            end else if (m_valid && (rt || c || j || h)) begin
                if (rt) begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_unf = 1; m_pc = 0; end
                end else if (c) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back((m_irpc + 1) % NADR);
                    else m_ovf = 1;
                    m_pc = adr;
                end else if (j) begin
                    m_pc = adr;
                end
                m_valid = 0;
                if (h) m_halted = 1;
            end else begin
                m_ir = m_pc;
                m_irpc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % NADR;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset values, then sequential fetch across the address wrap.
        do_reset();
        chk("rst_valid", ir_valid, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_pm_adr", pm_adr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ovf", stack_ovf, 0);
        chk("rst_unf", stack_unf, 0);
        for (int k = 0; k < 34; k++) begin
            tick();
            chk($sformatf("run%0d_valid", k), ir_valid, 1);
            chk($sformatf("run%0d_ir", k), ir, k % NADR);
            chk($sformatf("run%0d_ir_pc", k), ir_pc, k % NADR);
            chk($sformatf("run%0d_pm_adr", k), pm_adr, (k + 1) % NADR);
        end

        // Stall with an ignored jump, jump bubble, halt and reset override.
        v(0,1,0,0,0,0,0,  0,0,0,0);
        for (int k = 0; k < 6; k++) v(1,1,0,0,0,0,0, 1,k,k+1,0);
        v(1,0,0,0,0,0,0,  1,5,6,0);
        v(1,0,1,0,0,0,20, 1,5,6,0);
        v(1,0,0,0,0,0,0,  1,5,6,0);
        v(1,1,0,0,0,0,0,  1,6,7,0);
        v(1,1,0,0,0,0,0,  1,7,8,0);
        v(0,1,0,0,0,0,0,  0,0,0,0);
        for (int k = 0; k < 4; k++) v(1,1,0,0,0,0,0, 1,k,k+1,0);
        v(1,1,1,0,0,0,20, 0,0,20,0);
        v(1,1,0,0,0,0,0,  1,20,21,0);
        v(1,1,0,0,0,0,0,  1,21,22,0);
        v(0,1,0,0,0,0,0,  0,0,0,0);
        for (int k = 0; k < 8; k++) v(1,1,0,0,0,0,0, 1,k,k+1,0);
        v(1,1,0,0,0,1,0,  0,0,8,1);
        v(1,1,0,0,0,0,0,  0,0,8,1);
        v(1,1,1,1,1,1,3,  0,0,8,1);
        v(0,1,1,0,0,1,20, 0,0,0,0);
        v(1,1,0,0,0,0,0,  1,0,1,0);
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; ir_ready = tbl[i].ready; jmp_en = tbl[i].jmp;
            call_en = tbl[i].call; ret_en = tbl[i].ret; halt = tbl[i].hlt;
            jmp_adr = AW'(tbl[i].adr);
            tick();
            chk($sformatf("tbl%0d_valid", i), ir_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_pm_adr", i), pm_adr, tbl[i].exp_pm);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].exp_halted);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_ir", i), ir, tbl[i].exp_at);
                chk($sformatf("tbl%0d_ir_pc", i), ir_pc, tbl[i].exp_at);
            end
        end

        // Call to 10 from 4, return from 12 back to 5, then return on empty stack.
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        chk("cr_pre_ir_pc", ir_pc, 4);
        call_en = 1'b1; jmp_adr = 5'd10;
        tick();
        call_en = 1'b0;
        chk("cr_call_bubble", ir_valid, 0);
        chk("cr_call_pm", pm_adr, 10);
        for (int k = 10; k <= 12; k++) begin
            tick();
            chk($sformatf("cr_ir%0d", k), ir, k);
            chk($sformatf("cr_valid%0d", k), ir_valid, 1);
        end
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("cr_ret_bubble", ir_valid, 0);
        chk("cr_ret_pm", pm_adr, 5);
        tick();
        chk("cr_ret_ir", ir, 5);
        chk("cr_ret_ir_pc", ir_pc, 5);
        chk("cr_unf_clear", stack_unf, 0);
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("cr_empty_unf", stack_unf, 1);
        chk("cr_empty_pm", pm_adr, 0);
        tick();
        chk("cr_empty_ir_pc", ir_pc, 0);

        // Five nested calls overflow a four-deep stack; unwind, then underflow.
        do_reset();
        tick();
        for (int c = 0; c < 5; c++) begin
            call_en = 1'b1; jmp_adr = AW'(8 + 4 * c);
            tick();
            call_en = 1'b0;
            chk($sformatf("nest%0d_bubble", c), ir_valid, 0);
            chk($sformatf("nest%0d_pm", c), pm_adr, 8 + 4 * c);
            chk($sformatf("nest%0d_ovf", c), stack_ovf, (c == 4) ? 1 : 0);
            tick();
            chk($sformatf("nest%0d_ir", c), ir, 8 + 4 * c);
        end
        begin
            int exp_ret[4] = '{17, 13, 9, 1};
            for (int r = 0; r < 4; r++) begin
                ret_en = 1'b1;
                tick();
                ret_en = 1'b0;
                chk($sformatf("unwind%0d_pm", r), pm_adr, exp_ret[r]);
                chk($sformatf("unwind%0d_unf", r), stack_unf, 0);
                tick();
                chk($sformatf("unwind%0d_ir", r), ir, exp_ret[r]);
            end
        end
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("nest_unf", stack_unf, 1);
        chk("nest_ovf_sticky", stack_ovf, 1);
        tick();
        chk("nest_unf_ir_pc", ir_pc, 0);
        chk("nest_unf_valid", ir_valid, 1);

        // Randomised run against the reference model.
        do_reset();
        model_step(0, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, rdy, j, c, rt, h;
            int   adr;
            r   = ($urandom_range(0, 199) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 7) == 0);
            c   = ($urandom_range(0, 9) == 0);
            rt  = ($urandom_range(0, 9) == 0);
            h   = ($urandom_range(0, 149) == 0);
            adr = $urandom_range(0, NADR - 1);
            rst_n = r; ir_ready = rdy; jmp_en = j; call_en = c; ret_en = rt; halt = h;
            jmp_adr = AW'(adr);
            model_step(r, rdy, j, c, rt, h, adr);
            tick();
            chk($sformatf("rnd%0d_valid", n), ir_valid, m_valid);
            chk($sformatf("rnd%0d_pm_adr", n), pm_adr, m_pc);
            chk($sformatf("rnd%0d_halted", n), halted, m_halted);
            chk($sformatf("rnd%0d_ovf", n), stack_ovf, m_ovf);
            chk($sformatf("rnd%0d_unf", n), stack_unf, m_unf);
            if (m_valid) begin
                chk($sformatf("rnd%0d_ir", n), ir, m_ir);
                chk($sformatf("rnd%0d_ir_pc", n), ir_pc, m_irpc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
